// File: rtl/byte_serial_subtractor_pkg.sv
// Shared definitions for the byte-serial subtractor: FSM state encoding,
// default geometry and a helper for sizing the slice counter.
package byte_serial_subtractor_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_serial_subtractor_sub_slice.sv
// SLICE-bit ripple-carry adder; the caller supplies the inverted subtrahend
// so the same cell performs one slice of a - b - borrow.
module sub_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b_n,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < SLICE; i++) begin
      sum[i]   = a[i] ^ b_n[i] ^ c[i];
      c[i+1]   = (a[i] & b_n[i]) | (c[i] & (a[i] ^ b_n[i]));
    end
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/byte_serial_subtractor.sv
// Computes input1 - input2 - bin one SLICE per clock through a single shared
// ripple slice; result, bout and overflow are registered at completion.
module byte_serial_subtractor
  import byte_serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout,
  output logic             overflow
);

  localparam int unsigned    NSL  = WIDTH / SLICE;
  localparam int unsigned    CW   = cnt_width(NSL);
  localparam logic [CW-1:0]  LAST = CW'(NSL - 1);
  localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}});

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               bout_q, bout_d, ovf_q, ovf_d, done_q, done_d;

  logic [31:0]        sh;
  logic [SLICE-1:0]   a_sl, b_sl, sum_sl;
  logic               cout_sl;

  // Slice select/insert by shifting keeps index widths independent of WIDTH.
  always_comb begin
    sh   = 32'(cnt_q) * SLICE;
    a_sl = SLICE'(a_q >> sh);
    b_sl = SLICE'(b_q >> sh);
  end

  sub_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a    (a_sl),
    .b_n  (~b_sl),
    .cin  (carry_q),
    .sum  (sum_sl),
    .cout (cout_sl)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = input1;
          b_d     = input2;
          cnt_d   = '0;
          carry_d = ~bin;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = (acc_q & ~(MASK << sh)) | (WIDTH'(sum_sl) << sh);
        carry_d = cout_sl;
        if (cnt_q == LAST) begin
          result_d = acc_d;
          bout_d   = ~cout_sl;
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (acc_d[WIDTH-1] != a_q[WIDTH-1]);
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign ready    = (state_q != RUN);
  assign done     = done_q;
  assign result   = result_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: doc/byte_serial_subtractor.md
BYTE_SERIAL_SUBTRACTOR -- requirements
Module: byte_serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; SHALL be an integer multiple of SLICE.
REQ-002 Parameter: SLICE, 8, bits processed per clock cycle.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-006 Port: input1  input  WIDTH  minuend; sampled with start.
REQ-007 Port: input2  input  WIDTH  subtrahend; sampled with start.
REQ-008 Port: bin  input  1  borrow-in; sampled with start.
REQ-009 Port: ready  output  1  high when start will be accepted.
REQ-010 Port: done  output  1  one-cycle pulse; result, bout and overflow are valid.
REQ-011 Port: result  output  WIDTH  input1 - input2 - bin, modulo 2^WIDTH.
REQ-012 Port: bout  output  1  borrow-out; 1 when the unsigned input1 < input2 + bin.
REQ-013 Port: overflow  output  1  two's-complement overflow of the signed subtraction.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE; ready SHALL be high in IDLE and DONE and low in RUN.
REQ-015 When start=1 and ready=1 on a clock edge, the block SHALL latch input1, input2 and bin, clear the slice counter, set the internal carry to ~bin, and enter RUN.
REQ-016 In RUN, each edge SHALL compute slice k = counter: sum = a[k] + ~b[k] + carry; the block SHALL store the sum into the accumulator slice k, update carry, and increment counter (LSB slice first).
REQ-017 At the edge that processes slice WIDTH/SLICE-1, the block SHALL load the accumulator into result, set bout = ~final carry, set overflow = (a[MSB]!=b[MSB]) & (result[MSB]!=a[MSB]), and enter DONE.
REQ-018 done SHALL be registered and high only in DONE, for exactly one cycle, i.e. WIDTH/SLICE edges after the accepting edge (4 for defaults).
REQ-019 DONE SHALL go to RUN if start=1 (a new acceptance per REQ-015), otherwise to IDLE; the sustained throughput SHALL be one operation per WIDTH/SLICE+1 cycles.
REQ-020 start SHALL be ignored while in RUN; the latched operands SHALL be unaffected by input changes after acceptance.
REQ-021 result, bout and overflow SHALL hold their values from completion until the next completion; partial sums SHALL never appear on result.
REQ-022 The slice counter SHALL be $clog2(WIDTH/SLICE) bits wide (minimum 1) and SHALL not wrap within an operation.

Reset
REQ-023 While rst_n=0, state SHALL be IDLE, ready=1, done=0, result=0, bout=0, overflow=0, and the counter, carry and accumulator SHALL be 0, regardless of clk.
REQ-024 Reset asserted mid-operation SHALL abort the operation without a done pulse; the first start after release SHALL be accepted normally.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and the WIDTH/SLICE defaults.
REQ-026 One sub-module, sub_slice, SHALL implement the SLICE-bit ripple adder with inputs a, ~b and cin, and outputs sum and cout; it SHALL be instantiated once and time-shared.
REQ-027 The top level SHALL contain only the FSM, counter, operand/accumulator registers and output registers; the expected RTL size is 120-400 lines.

Verification
REQ-028 input1=0x00000005, input2=0x00000003, bin=0 -> done 4 edges after acceptance; result=0x00000002, bout=0, overflow=0.
REQ-029 input1=0x00000000, input2=0x00000001, bin=0 -> result=0xFFFFFFFF, bout=1, overflow=0.
REQ-030 input1=0x80000000, input2=0x00000001, bin=0 -> result=0x7FFFFFFF, bout=0, overflow=1; input1=0x12345678, input2=0x12345678, bin=1 -> result=0xFFFFFFFF, bout=1.
REQ-031 Apply start=1 continuously with new operands each cycle -> acceptance only in IDLE/DONE, one done every 5 cycles, and each result matches the operands latched at its own acceptance.
REQ-032 Assert rst_n=0 on the 2nd RUN cycle -> all outputs zero immediately and no done; after release, 0x00000010-0x00000001 -> result=0x0000000F on schedule.
